// File: rtl/periph_bus_arbiter.sv
// Round-robin two-master arbiter for the RAM/GPIO/Timer peripheral bus.
// Each granted access runs IDLE -> ACCESS -> CAPTURE -> RESP with registered outputs.
module periph_bus_arbiter #(
    parameter logic [3:0] RAM_REGION   = 4'h0,
    parameter logic [3:0] GPIO_REGION  = 4'h1,
    parameter logic [3:0] TIMER_REGION = 4'h2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_l_or_s,
    output logic        m0_gnt,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_l_or_s,
    output logic        m1_gnt,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    output logic        p_w_r,
    output logic        ram_sel,
    output logic        gpio_sel,
    output logic        timer_sel,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] gpio_rdata,
    input  logic [31:0] timer_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        lastGrant_q, lastGrant_d;
    logic        winner_q, winner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        loadStore_q, loadStore_d;
    logic        pwr_q, pwr_d;
    logic [2:0]  sel_q, sel_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        win;
    logic [31:0] winAddr;
    logic [31:0] capData;

    // Select vector is {timer, gpio, ram}; an unmapped region yields all-zero.
    function automatic logic [2:0] decodeRegion(input logic [3:0] region);
        logic [2:0] s;
        s = 3'b000;
        if (region == RAM_REGION)
            s = 3'b001;
        else if (region == GPIO_REGION)
            s = 3'b010;
        else if (region == TIMER_REGION)
            s = 3'b100;
        return s;
    endfunction

    always_comb begin
        if (m0_req && m1_req)
            win = ~lastGrant_q;
        else
            win = m1_req;
        winAddr = win ? m1_addr : m0_addr;

        capData = 32'h0;
        if (loadStore_q) begin
            unique case (sel_q)
                3'b001:  capData = ram_rdata;
                3'b010:  capData = gpio_rdata;
                3'b100:  capData = timer_rdata;
                default: capData = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        winner_d    = winner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        loadStore_d = loadStore_q;
        pwr_d       = pwr_q;
        sel_d       = sel_q;
        gnt_d       = 2'b00;
        ready_d     = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    winner_d    = win;
                    lastGrant_d = win;
                    addr_d      = winAddr;
                    wdata_d     = win ? m1_wdata : m0_wdata;
                    loadStore_d = win ? m1_l_or_s : m0_l_or_s;
                    pwr_d       = win ? m1_l_or_s : m0_l_or_s;
                    sel_d       = decodeRegion(winAddr[31:28]);
                    gnt_d[win]  = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                // The store already happened on this edge; block a repeat write.
                pwr_d   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (winner_q)
                    rdata1_d = capData;
                else
                    rdata0_d = capData;
                ready_d[winner_q] = 1'b1;
                err_d[winner_q]   = (sel_q == 3'b000);
                sel_d             = 3'b000;
                state_d           = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset leaves master 0 as first winner by recording master 1 as last grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            winner_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            loadStore_q <= 1'b1;
            pwr_q       <= 1'b1;
            sel_q       <= 3'b000;
            gnt_q       <= 2'b00;
            ready_q     <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            winner_q    <= winner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            loadStore_q <= loadStore_d;
            pwr_q       <= pwr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_ready  = ready_q[0];
    assign m1_ready  = ready_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign p_addr    = addr_q;
    assign p_wdata   = wdata_q;
    assign p_w_r     = pwr_q;
    assign ram_sel   = sel_q[0];
    assign gpio_sel  = sel_q[1];
    assign timer_sel = sel_q[2];

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter; responses are checked by a queue-based
// scoreboard while the stimulus tasks check grant/select timing directly.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0Req, m1Req;
    logic [31:0] m0Addr, m1Addr, m0Wdata, m1Wdata;
    logic        m0Ls, m1Ls;
    logic        m0Gnt, m1Gnt, m0Ready, m1Ready, m0Err, m1Err;
    logic [31:0] m0Rdata, m1Rdata;
    logic [31:0] pAddr, pWdata;
    logic        pWr;
    logic        ramSel, gpioSel, timerSel;
    logic [31:0] ramRdata, gpioRdata, timerRdata;
    logic [2:0]  sel;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t expQ[$];
    int    total = 0;
    int    bad   = 0;

    assign sel = {timerSel, gpioSel, ramSel};

    periph_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req      (m0Req),
        .m0_addr     (m0Addr),
        .m0_wdata    (m0Wdata),
        .m0_l_or_s   (m0Ls),
        .m0_gnt      (m0Gnt),
        .m0_ready    (m0Ready),
        .m0_rdata    (m0Rdata),
        .m0_err      (m0Err),
        .m1_req      (m1Req),
        .m1_addr     (m1Addr),
        .m1_wdata    (m1Wdata),
        .m1_l_or_s   (m1Ls),
        .m1_gnt      (m1Gnt),
        .m1_ready    (m1Ready),
        .m1_rdata    (m1Rdata),
        .m1_err      (m1Err),
        .p_addr      (pAddr),
        .p_wdata     (pWdata),
        .p_w_r       (pWr),
        .ram_sel     (ramSel),
        .gpio_sel    (gpioSel),
        .timer_sel   (timerSel),
        .ram_rdata   (ramRdata),
        .gpio_rdata  (gpioRdata),
        .timer_rdata (timerRdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest queued response.
    always @(negedge clk) begin
        resp_t r;
        checkOutput("selOneHot", 32'($countones(sel) <= 1), 32'd1);
        if (m0Ready || m1Ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedReady", {30'h0, m1Ready, m0Ready}, 32'h0);
            end else begin
                r = expQ.pop_front();
                checkOutput("respMaster", {30'h0, m1Ready, m0Ready}, r.master ? 32'd2 : 32'd1);
                checkOutput("respRdata", r.master ? m1Rdata : m0Rdata, r.rdata);
                checkOutput("respErr", 32'(r.master ? m1Err : m0Err), 32'(r.err));
                checkOutput("otherErr", 32'(r.master ? m0Err : m1Err), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic master, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic ls, input logic [2:0] expSel,
                                 input logic [31:0] expRdata, input logic expErr);
        resp_t r;
        int    waited;
        logic  seen;
        @(posedge clk); #1;
        if (master) begin
            m1Req = 1'b1; m1Addr = addr; m1Wdata = wdata; m1Ls = ls;
        end else begin
            m0Req = 1'b1; m0Addr = addr; m0Wdata = wdata; m0Ls = ls;
        end
        r.master = master; r.rdata = expRdata; r.err = expErr;
        expQ.push_back(r);

        @(posedge clk); #1;
        checkOutput("gntAccess", {30'h0, m1Gnt, m0Gnt}, master ? 32'd2 : 32'd1);
        checkOutput("selAccess", 32'(sel), 32'(expSel));
        checkOutput("pwrAccess", 32'(pWr), 32'(ls));
        checkOutput("pAddrAccess", pAddr, addr);
        checkOutput("pWdataAccess", pWdata, wdata);
        if (master) begin
            m1Req = 1'b0; m1Addr = 32'hFFFF_FFFF; m1Wdata = 32'h0; m1Ls = ~ls;
        end else begin
            m0Req = 1'b0; m0Addr = 32'hFFFF_FFFF; m0Wdata = 32'h0; m0Ls = ~ls;
        end

        @(posedge clk); #1;
        checkOutput("gntCapture", {30'h0, m1Gnt, m0Gnt}, 32'd0);
        checkOutput("selCapture", 32'(sel), 32'(expSel));
        checkOutput("pwrCapture", 32'(pWr), 32'd1);
        checkOutput("pAddrCapture", pAddr, addr);

        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            waited = i;
            if (master ? m1Ready : m0Ready) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("readySeen", 32'(seen), 32'd1);
        checkOutput("readyLatency", 32'(waited), 32'd1);

        @(posedge clk); #1;
        checkOutput("selIdle", 32'(sel), 32'd0);
        checkOutput("readyIdle", {30'h0, m1Ready, m0Ready}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int gntCount;
        int readyCount;
        rst = 1'b0;
        m0Req = 1'b0; m0Addr = 32'h0; m0Wdata = 32'h0; m0Ls = 1'b1;
        m1Req = 1'b0; m1Addr = 32'h0; m1Wdata = 32'h0; m1Ls = 1'b1;
        ramRdata = 32'h0; gpioRdata = 32'h5555_AAAA; timerRdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstGnt", {30'h0, m1Gnt, m0Gnt}, 32'd0);
        checkOutput("rstReady", {28'h0, m1Ready, m0Ready, m1Err, m0Err}, 32'd0);
        checkOutput("rstSel", 32'(sel), 32'd0);
        checkOutput("rstPwr", 32'(pWr), 32'd1);
        checkOutput("rstPAddr", pAddr, 32'h0);
        checkOutput("rstPWdata", pWdata, 32'h0);
        checkOutput("rstM0Rdata", m0Rdata, 32'h0);
        checkOutput("rstM1Rdata", m1Rdata, 32'h0);
        rst = 1'b1;

        $display("[TB] master 0 store to GPIO");
        applyStimulus(1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0, 3'b010, 32'h0, 1'b0);

        $display("[TB] master 1 load from RAM");
        ramRdata = 32'h1234_5678;
        applyStimulus(1'b1, 32'h0000_0010, 32'h0, 1'b1, 3'b001, 32'h1234_5678, 1'b0);

        $display("[TB] master 0 load from Timer");
        timerRdata = 32'hCAFE_0001;
        applyStimulus(1'b0, 32'h2000_0008, 32'h0, 1'b1, 3'b100, 32'hCAFE_0001, 1'b0);
        checkOutput("m1RdataHold", m1Rdata, 32'h1234_5678);

        $display("[TB] unmapped load and store");
        applyStimulus(1'b1, 32'h7000_0000, 32'h0, 1'b1, 3'b000, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'hF000_0000, 32'h1111_2222, 1'b0, 3'b000, 32'h0, 1'b1);

        gntCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0Gnt || m1Gnt) gntCount++;
        end
        checkOutput("noRegrantAfterDrop", 32'(gntCount), 32'd0);

        $display("[TB] reset during ACCESS");
        @(posedge clk); #1;
        m0Req = 1'b1; m0Addr = 32'h0000_0040; m0Ls = 1'b0; m0Wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        checkOutput("abortGnt", 32'(m0Gnt), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abortSel", 32'(sel), 32'd0);
        checkOutput("abortGntLow", {30'h0, m1Gnt, m0Gnt}, 32'd0);
        checkOutput("abortReady", {30'h0, m1Ready, m0Ready}, 32'd0);
        checkOutput("abortPwr", 32'(pWr), 32'd1);
        m0Req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        readyCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (m0Ready || m1Ready) readyCount++;
        end
        checkOutput("noReadyAfterAbort", 32'(readyCount), 32'd0);
        checkOutput("pwrAfterAbort", 32'(pWr), 32'd1);

        $display("[TB] simultaneous requests from reset");
        ramRdata = 32'hA5A5_0001;
        @(posedge clk); #1;
        m0Req = 1'b1; m0Addr = 32'h0000_0100; m0Ls = 1'b1;
        m1Req = 1'b1; m1Addr = 32'h0000_0200; m1Ls = 1'b1;
        for (int k = 0; k < 4; k++) begin
            resp_t r;
            r.master = k[0]; r.rdata = 32'hA5A5_0001; r.err = 1'b0;
            expQ.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput("rrGrant", {30'h0, m1Gnt, m0Gnt}, k[0] ? 32'd2 : 32'd1);
            checkOutput("rrAddr", pAddr, k[0] ? 32'h0000_0200 : 32'h0000_0100);
            if (k == 3) begin
                m0Req = 1'b0;
                m1Req = 1'b0;
            end else begin
                repeat (3) @(posedge clk);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and sequencer for the shared peripheral bus (RAM, GPIO, Timer). It accepts load/store requests from the CPU memory stage (master 0) and a secondary requester such as a DMA or debug port (master 1), and grants masters round-robin. For each granted access it decodes the address into exactly one peripheral select and sequences that access over a fixed four-state cycle. It returns registered read data with a ready pulse, and flags accesses to unmapped addresses with an error pulse.

## Interface
- RAM_REGION, 4'h0, value of addr[31:28] selecting RAM
- GPIO_REGION, 4'h1, value of addr[31:28] selecting GPIO
- TIMER_REGION, 4'h2, value of addr[31:28] selecting Timer
- clk  in  1  system clock; all flops rising-edge
- rst  in  1  asynchronous, active-low reset
- mN_req  in  1  (N=0,1) access request; held until mN_ready
- mN_addr  in  32  byte address
- mN_wdata  in  32  store data
- mN_l_or_s  in  1  1 = load, 0 = store
- mN_gnt  out  1  one-cycle pulse: request latched
- mN_ready  out  1  one-cycle pulse: access complete
- mN_rdata  out  32  load data; valid while mN_ready=1
- mN_err  out  1  one-cycle pulse with mN_ready: unmapped address
- p_addr  out  32  latched address to peripherals
- p_wdata  out  32  latched store data
- p_w_r  out  1  1 = load, 0 = store (write strobe when 0 and a select is high)
- ram_sel, gpio_sel, timer_sel  out  1  one-hot peripheral select
- ram_rdata, gpio_rdata, timer_rdata  in  32  registered peripheral read data

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All outputs are registered.
- **IDLE**
  - If any mN_req is high, pick a winner and latch its addr, wdata and l_or_s. Pulse the winner's gnt, then go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration**
  - Round-robin on a last_grant bit.
  - If both masters request, the master that is not last_grant wins.
  - If one master requests, it wins regardless of last_grant.
  - last_grant updates on every grant.
- **Address decode**
  - Decode addr[31:28] against the three region parameters. A hit sets exactly one select; a miss sets none.
- **ACCESS**
  - Drive the decoded select, p_addr, p_wdata and p_w_r = latched l_or_s. A store is written by the peripheral at the end of this cycle.
  - Next state is CAPTURE.
- **CAPTURE**
  - Select, p_addr and p_wdata are held. p_w_r is forced to 1 so no second write occurs.
  - At the end of this cycle, register the selected peripheral's rdata into the winner's rdata. Use 0 for stores and for unmapped addresses.
  - Next state is RESP.
- **RESP**
  - Pulse the winner's ready. Pulse err as well if the address was unmapped. All selects are low.
  - Next state is IDLE. A new request can be granted at the end of the IDLE cycle that follows.
- **Idle master outputs:** the non-winning master's gnt, ready and err stay 0. Its rdata holds its last value.
- **Request dropped after gnt:** the latched transaction still completes; ready and err still pulse.
- **Request changed after gnt:** no effect on the transaction in flight.

## Timing
- **Reset values** (rst low, applied asynchronously):
  - state = IDLE, last_grant = 1 (so master 0 wins first).
  - All gnt, ready, err and select outputs = 0.
  - p_addr, p_wdata and all mN_rdata = 0; p_w_r = 1.
- **Cycle sequence** (request sampled high in IDLE during cycle T):
  - T+1: gnt and select high.
  - T+2: CAPTURE.
  - T+3: ready high and rdata valid.
  - T+4: IDLE.
- **Throughput:** one access per 4 cycles under back-to-back requests.
- **Write:** exactly one cycle of select with p_w_r = 0 per store; none for unmapped addresses.
- **Reset mid-transaction:** the access is aborted immediately and no ready is issued. A store that was in ACCESS may or may not have been written. After rst rises, masters must re-request.
- **Select encoding:** one-hot or all-zero at all times; never more than one select high.

## Test plan
- **Reset values:** pulse rst low mid-ACCESS -> all selects, gnt and ready go 0 at once; after release, state is IDLE and p_w_r = 1.
- **Master 0 store:** m0 stores 32'hDEAD_BEEF to 32'h1000_0004 -> gpio_sel and p_w_r = 0 for exactly one cycle at T+1; m0_ready at T+3; m0_err = 0.
- **Master 1 load:** m1 loads from 32'h0000_0010 with ram_rdata = 32'h1234_5678 -> m1_rdata = 32'h1234_5678 with m1_ready at T+3; ram_sel high during T+1 and T+2, p_w_r = 1.
- **Simultaneous requests:** m0 and m1 request together from reset and hold their requests -> grants alternate m0, m1, m0, m1, one every 4 cycles.
- **Unmapped load:** load from 32'h7000_0000 -> no select asserted; ready and err pulse together at T+3; rdata = 0.
- **Request dropped after gnt:** m0 drops req the cycle after m0_gnt -> m0_ready still pulses at T+3; no second grant to m0.
